// File: rtl/wb_sequencer.sv
// Write-back sequencer for the 8-bit core: decodes executed instructions into register-file,
// data-memory and PC-load strobes, splits MUL results into two writes and latches HALT.
module wb_sequencer #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_ADDR_W = 4,
  parameter int PC_W       = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            opcode,
  input  logic                  am,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [PC_W-1:0]       instr_mem_addr,
  input  logic [2*DATA_W-1:0]   alu_out,
  input  logic                  zero_flag,
  input  logic                  parity_flag,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  dm_we,
  output logic [MEM_ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  output logic                  pc_load,
  output logic [PC_W-1:0]       pc_value,
  output logic                  HALTED
);

  localparam logic [4:0] OP_MUL   = 5'b00011;
  localparam logic [4:0] OP_STORE = 5'b01100;
  localparam logic [4:0] OP_JUMP  = 5'b01101;
  localparam logic [4:0] OP_BEQZ  = 5'b01110;
  localparam logic [4:0] OP_BPAR  = 5'b11000;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [1:0] {S_IDLE, S_WR_HI, S_HALT} state_t;

  state_t state_q, state_d;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic                  dm_we_q, dm_we_d;
  logic [MEM_ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]     dm_wdata_q, dm_wdata_d;
  logic                  pc_load_q, pc_load_d;
  logic [PC_W-1:0]       pc_value_q, pc_value_d;
  logic                  halted_q, halted_d;
  logic [DATA_W-1:0]     hi_byte_q, hi_byte_d;
  logic [REG_ADDR_W-1:0] hi_addr_q, hi_addr_d;

  logic accept;
  logic is_alu;

  assign in_ready = (state_q == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign is_alu   = (opcode >= 5'd1) && (opcode <= 5'd11) && (opcode != OP_MUL);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && opcode == OP_MUL)       state_d = S_WR_HI;
        else if (accept && opcode == OP_HALT) state_d = S_HALT;
      end
      S_WR_HI: state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Data fields hold their previous values unless the matching strobe fires.
  always_comb begin
    rf_we_d    = 1'b0;
    dm_we_d    = 1'b0;
    pc_load_d  = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    pc_value_d = pc_value_q;
    hi_byte_d  = hi_byte_q;
    hi_addr_d  = hi_addr_q;
    halted_d   = (state_d == S_HALT);
    if (state_q == S_WR_HI) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = hi_addr_q;
      rf_wdata_d = hi_byte_q;
    end else if (accept) begin
      if ((is_alu && !am) || opcode == OP_MUL) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = rd;
        rf_wdata_d = alu_out[DATA_W-1:0];
      end
      if ((is_alu && am) || opcode == OP_STORE) begin
        dm_we_d    = 1'b1;
        dm_addr_d  = mem_addr;
        dm_wdata_d = alu_out[DATA_W-1:0];
      end
      if (opcode == OP_MUL) begin
        hi_byte_d = alu_out[2*DATA_W-1:DATA_W];
        hi_addr_d = rd + REG_ADDR_W'(1);
      end
      if (opcode == OP_JUMP || (opcode == OP_BEQZ && zero_flag) ||
          (opcode == OP_BPAR && parity_flag)) begin
        pc_load_d  = 1'b1;
        pc_value_d = instr_mem_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      pc_load_q  <= 1'b0;
      pc_value_q <= '0;
      halted_q   <= 1'b0;
      hi_byte_q  <= '0;
      hi_addr_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      pc_load_q  <= pc_load_d;
      pc_value_q <= pc_value_d;
      halted_q   <= halted_d;
      hi_byte_q  <= hi_byte_d;
      hi_addr_q  <= hi_addr_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign pc_load  = pc_load_q;
  assign pc_value = pc_value_q;
  assign HALTED   = halted_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: each driven instruction pushes its expected strobes
// (kind, address, data, cycle); a negedge monitor pops and compares every strobe it sees.
module tb_wb_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic        am;
  logic [2:0]  rd;
  logic [3:0]  mem_addr;
  logic [5:0]  instr_mem_addr;
  logic [15:0] alu_out;
  logic        zero_flag;
  logic        parity_flag;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        dm_we;
  logic [3:0]  dm_addr;
  logic [7:0]  dm_wdata;
  logic        pc_load;
  logic [5:0]  pc_value;
  logic        HALTED;

  wb_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .am(am), .rd(rd), .mem_addr(mem_addr),
    .instr_mem_addr(instr_mem_addr), .alu_out(alu_out),
    .zero_flag(zero_flag), .parity_flag(parity_flag),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .pc_load(pc_load), .pc_value(pc_value), .HALTED(HALTED)
  );

  always #5 clk = ~clk;

  localparam int K_RF = 1, K_DM = 2, K_PC = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input int addr, input int data, input int c);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input int addr, input int data);
    exp_t e;
    $display("cyc=%0d strobe kind=%0d addr=%0h data=%0h", cyc, kind, addr, data);
    if (sb.size() == 0) begin
      check_val("unexpected_strobe", 32'(kind), 32'd0);
    end else begin
      e = sb.pop_front();
      check_val("kind", 32'(kind), 32'(e.kind));
      check_val("addr", 32'(addr), 32'(e.addr));
      check_val("data", 32'(data), 32'(e.data));
      check_val("cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rf_we)   observe(K_RF, int'(rf_waddr), int'(rf_wdata));
    if (dm_we)   observe(K_DM, int'(dm_addr), int'(dm_wdata));
    if (pc_load) observe(K_PC, 0, int'(pc_value));
  end

  // Drives one instruction and returns the cycle stamp of its accept edge.
  task automatic send(input logic [4:0] op, input logic a, input logic [2:0] r,
                      input logic [3:0] ma, input logic [5:0] tgt, input logic [15:0] alu,
                      input logic z, input logic p, output int acc);
    bit got = 0;
    acc = -1;
    opcode = op; am = a; rd = r; mem_addr = ma; instr_mem_addr = tgt;
    alu_out = alu; zero_flag = z; parity_flag = p; in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      acc = cyc;
      #1;
    end
    in_valid = 1'b0;
    if (!got) check_val("accept_timeout", 32'd0, 32'd1);
    $display("cyc=%0d send op=%b am=%0d rd=%0d alu=%h", acc, op, a, r, alu);
  endtask

  int acc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; am = 1'b0; rd = '0; mem_addr = '0;
    instr_mem_addr = '0; alu_out = '0; zero_flag = 1'b0; parity_flag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_rf_we", 32'(rf_we), 32'd0);
    check_val("rst_dm_we", 32'(dm_we), 32'd0);
    check_val("rst_pc_load", 32'(pc_load), 32'd0);
    check_val("rst_halted", 32'(HALTED), 32'd0);
    check_val("rst_data", {rf_waddr, rf_wdata, dm_addr, dm_wdata, pc_value}, 32'd0);
    check_val("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ADD to r1
    send(5'b00001, 1'b0, 3'd1, 4'd0, 6'd0, 16'h00C0, 1'b0, 1'b0, acc);
    push(K_RF, 1, 'hC0, acc + 1);
    // INC to memory then STORE, back-to-back
    send(5'b00101, 1'b1, 3'd0, 4'd0, 6'd0, 16'h0003, 1'b0, 1'b0, acc);
    push(K_DM, 0, 'h03, acc + 1);
    send(5'b01100, 1'b0, 3'd0, 4'd2, 6'd0, 16'h0040, 1'b0, 1'b0, acc);
    push(K_DM, 2, 'h40, acc + 1);
    // NOP opcode produces nothing
    send(5'b10100, 1'b0, 3'd2, 4'd0, 6'd0, 16'h00AA, 1'b1, 1'b1, acc);

    // MUL r7: high byte wraps into r0
    send(5'b00011, 1'b1, 3'd7, 4'd9, 6'd0, 16'hFE40, 1'b0, 1'b0, acc);
    push(K_RF, 7, 'h40, acc + 1);
    push(K_RF, 0, 'hFE, acc + 2);
    @(negedge clk);
    check_val("mul_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_val("mul_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Branches and jump
    send(5'b01110, 1'b0, 3'd0, 4'd0, 6'd4, 16'h0000, 1'b0, 1'b0, acc);
    send(5'b01110, 1'b0, 3'd0, 4'd0, 6'd4, 16'h0000, 1'b1, 1'b0, acc);
    push(K_PC, 0, 4, acc + 1);
    send(5'b11000, 1'b0, 3'd0, 4'd0, 6'd5, 16'h0000, 1'b0, 1'b0, acc);
    send(5'b11000, 1'b0, 3'd0, 4'd0, 6'd5, 16'h0000, 1'b0, 1'b1, acc);
    push(K_PC, 0, 5, acc + 1);
    send(5'b01101, 1'b0, 3'd0, 4'd0, 6'd5, 16'h0000, 1'b0, 1'b0, acc);
    push(K_PC, 0, 5, acc + 1);

    // MUL r3 with reset in the WR_HI cycle: r4 write must be dropped
    send(5'b00011, 1'b0, 3'd3, 4'd0, 6'd0, 16'h1234, 1'b0, 1'b0, acc);
    push(K_RF, 3, 'h34, acc + 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mulrst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("mulrst_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(5'b00001, 1'b0, 3'd4, 4'd0, 6'd0, 16'h0055, 1'b0, 1'b0, acc);
    push(K_RF, 4, 'h55, acc + 1);

    // HALT, then an ADD held valid must be ignored
    send(5'b11111, 1'b0, 3'd0, 4'd0, 6'd0, 16'h0000, 1'b0, 1'b0, acc);
    opcode = 5'b00001; am = 1'b0; rd = 3'd2; alu_out = 16'h0077; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("halt_flag", 32'(HALTED), 32'd1);
      check_val("halt_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("unhalt_flag", 32'(HALTED), 32'd0);
    check_val("unhalt_ready", 32'(in_ready), 32'd1);

    repeat (3) @(negedge clk);
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
